// File: rtl/dbus_responder_pkg.sv
// dbus_map_pkg: address map, MMIO register offsets and STATUS bit positions
// for the data-bus responder.
// No ports (package); imported by the interface-side logic in dbus_responder.
package dbus_map_pkg;

  localparam logic [31:0] MMIO_BASE  = 32'h8000_0000;

  // MMIO byte offsets; only bits [4:2] take part in decode.
  localparam logic [4:0]  OFF_CYCLE  = 5'h00;
  localparam logic [4:0]  OFF_LEDS   = 5'h04;
  localparam logic [4:0]  OFF_TXDATA = 5'h08;
  localparam logic [4:0]  OFF_STATUS = 5'h0C;

  // STATUS register bit positions.
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_OVF   = 2;

  // Register select derived from a byte offset.
  function automatic logic [2:0] reg_sel(input logic [4:0] off);
    return off[4:2];
  endfunction

endpackage

// File: rtl/dbus_responder_if.sv
// dbus_responder_if: core data-memory bus plus LED and TX byte stream signals.
// Ports: mem_addr/mem_wdata/mem_write in, mem_rdata out (1-cycle read),
//        leds out, tx_data/tx_valid out with tx_ready in (valid/ready stream).
interface dbus_responder_if;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic [31:0] mem_rdata;
  logic [7:0]  leds;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  // Core side (also sources tx_ready on behalf of the downstream UART).
  modport master (
    output mem_addr, mem_wdata, mem_write, tx_ready,
    input  mem_rdata, leds, tx_data, tx_valid
  );

  // Responder side.
  modport slave (
    input  mem_addr, mem_wdata, mem_write, tx_ready,
    output mem_rdata, leds, tx_data, tx_valid
  );
endinterface

// File: rtl/dbus_responder_fifo.sv
// sync_fifo: single-clock FIFO, pointers wrap modulo DEPTH, separate count.
// Latency: push visible on dout/empty the cycle after the push edge.
// Backpressure: push ignored when full unless a pop happens in the same cycle.
// Ports: clk, reset (sync, active-high), push, pop, din in; dout, full, empty out.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic w_wr;
  logic w_rd;

  assign empty = (r_count == '0);
  assign full  = (r_count == (PW+1)'(DEPTH));

  // A pop frees the slot in the same edge, so push is accepted when full+pop.
  assign w_rd = pop && !empty;
  assign w_wr = push && (!full || w_rd);

  // Force zero while empty so stale storage never shows on the stream.
  assign dout = empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dbus_responder.sv
// dbus_responder: data-bus responder serving a word RAM and an MMIO block
// (cycle counter, LED register, TX byte FIFO with sticky overflow flag).
// Latency: read data 1 cycle; push to tx_valid 1 cycle.
// Backpressure: none toward the core; TX pushes into a full FIFO are dropped
//   and latch overflow; the stream side holds tx_data while tx_ready=0.
// Ports: clk, reset (sync, active-high), bus (dbus_responder_if.slave).
module dbus_responder
  import dbus_map_pkg::*;
#(
  parameter int RAM_WORDS  = 1024,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  dbus_responder_if.slave   bus
);

  localparam int AW = $clog2(RAM_WORDS);

  logic [31:0] r_ram [RAM_WORDS];
  logic [31:0] r_cycle;
  logic [31:0] r_rdata;
  logic [7:0]  r_leds;
  logic        r_ovf;

  logic          w_is_mmio;
  logic [2:0]    w_reg;
  logic [AW-1:0] w_word;
  logic          w_wr_ram;
  logic          w_wr_leds;
  logic          w_push;
  logic          w_clr_ovf;
  logic          w_pop;
  logic          w_drop;
  logic          w_full;
  logic          w_empty;
  logic [7:0]    w_fifo_dout;
  logic [31:0]   w_rd_mux;
  logic          w_unused_addr;

  assign w_is_mmio = bus.mem_addr[31];
  assign w_reg     = bus.mem_addr[4:2];
  assign w_word    = bus.mem_addr[AW+1:2];

  // Address bits outside the decoded fields alias by design.
  assign w_unused_addr = &{1'b0, bus.mem_addr[30:AW+2], bus.mem_addr[1:0]};

  assign w_wr_ram  = bus.mem_write && !w_is_mmio;
  assign w_wr_leds = bus.mem_write && w_is_mmio && (w_reg == reg_sel(OFF_LEDS));
  assign w_push    = bus.mem_write && w_is_mmio && (w_reg == reg_sel(OFF_TXDATA));
  assign w_clr_ovf = bus.mem_write && w_is_mmio && (w_reg == reg_sel(OFF_STATUS))
                     && bus.mem_wdata[ST_OVF];

  assign w_pop  = !w_empty && bus.tx_ready;
  // A push into a full FIFO is only lost if nothing leaves this cycle.
  assign w_drop = w_push && w_full && !w_pop;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (w_push),
    .pop   (w_pop),
    .din   (bus.mem_wdata[7:0]),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  // RAM: full-word writes, no reset; the read mux sees pre-edge contents,
  // which gives read-first behaviour on a same-word collision.
  always_ff @(posedge clk) begin
    if (w_wr_ram) begin
      r_ram[w_word] <= bus.mem_wdata;
    end
  end

  // Read mux over pre-edge state; registered below with no side effects.
  always_comb begin
    w_rd_mux = '0;
    if (!w_is_mmio) begin
      w_rd_mux = r_ram[w_word];
    end else begin
      case (w_reg)
        reg_sel(OFF_CYCLE):  w_rd_mux = r_cycle;
        reg_sel(OFF_LEDS):   w_rd_mux = {24'b0, r_leds};
        reg_sel(OFF_STATUS): begin
          w_rd_mux[ST_EMPTY] = w_empty;
          w_rd_mux[ST_FULL]  = w_full;
          w_rd_mux[ST_OVF]   = r_ovf;
        end
        default:             w_rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cycle <= '0;
      r_rdata <= '0;
      r_leds  <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_cycle <= r_cycle + 32'd1;
      r_rdata <= w_rd_mux;
      if (w_wr_leds) r_leds <= bus.mem_wdata[7:0];
      // Set has priority over a clear in the same cycle.
      if (w_drop)         r_ovf <= 1'b1;
      else if (w_clr_ovf) r_ovf <= 1'b0;
    end
  end

  assign bus.mem_rdata = r_rdata;
  assign bus.leds      = r_leds;
  assign bus.tx_data   = w_fifo_dout;
  assign bus.tx_valid  = !w_empty;

endmodule

// File: tb/tb_dbus_responder.sv
// tb_dbus_responder: directed self-checking bench for dbus_responder.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_dbus_responder;

  logic clk;
  logic reset;
  int   checks;
  int   failures;

  dbus_responder_if bus ();

  dbus_responder #(
    .RAM_WORDS  (1024),
    .FIFO_DEPTH (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic wr);
    bus.mem_addr  = addr;
    bus.mem_wdata = wdata;
    bus.mem_write = wr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tx_ready = 1'b0;
    drive(32'h8000_0000, 32'h0, 1'b0);
    step();
    step();
    checks++;
    if (bus.mem_rdata !== 32'h0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=%h", bus.mem_rdata, 32'h0);
    end
    checks++;
    if (bus.leds !== 8'h00) begin
      failures++; $display("FAIL reset_leds got=%h exp=%h", bus.leds, 8'h00);
    end
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00) begin
      failures++; $display("FAIL reset_tx got valid=%b data=%h exp valid=0 data=00", bus.tx_valid, bus.tx_data);
    end
  endtask

  // Reset still asserted on entry with CYCLE address presented.
  task automatic test_cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.mem_rdata !== 32'(i)) begin
        failures++; $display("FAIL cycle_read%0d got=%h exp=%h", i, bus.mem_rdata, 32'(i));
      end
    end
  endtask

  task automatic test_ram();
    drive(32'h0000_0010, 32'hDEAD_BEEF, 1'b1);
    step();
    drive(32'h0000_0010, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ram_roundtrip got=%h exp=%h", bus.mem_rdata, 32'hDEAD_BEEF);
    end
    drive(32'h0000_1010, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL ram_alias got=%h exp=%h", bus.mem_rdata, 32'hDEAD_BEEF);
    end
    drive(32'h0000_0014, 32'h1234_5678, 1'b1);
    step();
    drive(32'h0000_0014, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'h1234_5678) begin
      failures++; $display("FAIL ram_word14 got=%h exp=%h", bus.mem_rdata, 32'h1234_5678);
    end
  endtask

  task automatic test_collision();
    drive(32'h0000_0080, 32'h1111_1111, 1'b1);
    step();
    drive(32'h0000_0080, 32'h2222_2222, 1'b1);
    step();
    checks++;
    if (bus.mem_rdata !== 32'h1111_1111) begin
      failures++; $display("FAIL collision_old got=%h exp=%h", bus.mem_rdata, 32'h1111_1111);
    end
    drive(32'h0000_0080, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'h2222_2222) begin
      failures++; $display("FAIL collision_new got=%h exp=%h", bus.mem_rdata, 32'h2222_2222);
    end
  endtask

  task automatic test_leds();
    drive(32'h8000_0004, 32'h0000_01A5, 1'b1);
    step();
    drive(32'h8000_0004, 32'h0, 1'b0);
    checks++;
    if (bus.leds !== 8'hA5) begin
      failures++; $display("FAIL leds_out got=%h exp=%h", bus.leds, 8'hA5);
    end
    step();
    checks++;
    if (bus.mem_rdata !== 32'h0000_00A5) begin
      failures++; $display("FAIL leds_read got=%h exp=%h", bus.mem_rdata, 32'h0000_00A5);
    end
    drive(32'h8000_0008, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'h0) begin
      failures++; $display("FAIL txdata_read got=%h exp=%h", bus.mem_rdata, 32'h0);
    end
    drive(32'h8000_0014, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'h0) begin
      failures++; $display("FAIL rsvd_read got=%h exp=%h", bus.mem_rdata, 32'h0);
    end
  endtask

  task automatic test_tx_stream();
    logic [7:0] exp_b [3];
    exp_b[0] = 8'h41; exp_b[1] = 8'h42; exp_b[2] = 8'h43;
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(32'h8000_0008, {24'h0, exp_b[i]}, 1'b1);
      step();
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h41) begin
        failures++; $display("FAIL tx_hold%0d got valid=%b data=%h exp valid=1 data=41", i, bus.tx_valid, bus.tx_data);
      end
    end
    drive(32'h8000_000C, 32'h0, 1'b0);
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_b[i]) begin
        failures++; $display("FAIL tx_order%0d got valid=%b data=%h exp valid=1 data=%h", i, bus.tx_valid, bus.tx_data, exp_b[i]);
      end
      step();
    end
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      failures++; $display("FAIL tx_drained got=%b exp=0", bus.tx_valid);
    end
    step();
    checks++;
    if (bus.mem_rdata !== 32'h1) begin
      failures++; $display("FAIL tx_status got=%h exp=%h", bus.mem_rdata, 32'h1);
    end
    // Push and pop together at count 1: head replaced, valid stays high.
    bus.tx_ready = 1'b0;
    drive(32'h8000_0008, 32'h70, 1'b1);
    step();
    bus.tx_ready = 1'b1;
    drive(32'h8000_0008, 32'h71, 1'b1);
    step();
    checks++;
    if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h71) begin
      failures++; $display("FAIL tx_count1 got valid=%b data=%h exp valid=1 data=71", bus.tx_valid, bus.tx_data);
    end
    drive(32'h8000_000C, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      failures++; $display("FAIL tx_count1_drain got=%b exp=0", bus.tx_valid);
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_overflow();
    logic [7:0] exp_d [8];
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      drive(32'h8000_0008, 32'(8'h50 + i), 1'b1);
      step();
    end
    drive(32'h8000_000C, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'h6) begin
      failures++; $display("FAIL ovf_status got=%h exp=%h", bus.mem_rdata, 32'h6);
    end
    drive(32'h8000_000C, 32'h4, 1'b1);
    step();
    drive(32'h8000_000C, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'h2) begin
      failures++; $display("FAIL ovf_clear got=%h exp=%h", bus.mem_rdata, 32'h2);
    end
    drive(32'h8000_0008, 32'h60, 1'b1);
    bus.tx_ready = 1'b1;
    step();
    bus.tx_ready = 1'b0;
    drive(32'h8000_000C, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'h2) begin
      failures++; $display("FAIL full_pushpop_status got=%h exp=%h", bus.mem_rdata, 32'h2);
    end
    for (int i = 0; i < 7; i++) exp_d[i] = 8'(8'h51 + i);
    exp_d[7] = 8'h60;
    bus.tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_d[i]) begin
        failures++; $display("FAIL ovf_drain%0d got valid=%b data=%h exp valid=1 data=%h", i, bus.tx_valid, bus.tx_data, exp_d[i]);
      end
      step();
    end
    checks++;
    if (bus.tx_valid !== 1'b0) begin
      failures++; $display("FAIL ovf_empty got=%b exp=0", bus.tx_valid);
    end
    bus.tx_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(32'h8000_0008, 32'(8'h30 + i), 1'b1);
      step();
    end
    drive(32'h8000_0004, 32'hFF, 1'b1);
    step();
    drive(32'h8000_0000, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.leds !== 8'hFF || bus.tx_valid !== 1'b1 || bus.mem_rdata === 32'h0) begin
      failures++; $display("FAIL premid_state got leds=%h valid=%b cycle=%h exp leds=ff valid=1 cycle!=0", bus.leds, bus.tx_valid, bus.mem_rdata);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.leds !== 8'h00 || bus.mem_rdata !== 32'h0) begin
      failures++; $display("FAIL mid_reset got valid=%b leds=%h rdata=%h exp 0/00/0", bus.tx_valid, bus.leds, bus.mem_rdata);
    end
    step();
    checks++;
    if (bus.mem_rdata !== 32'h0) begin
      failures++; $display("FAIL mid_cycle got=%h exp=%h", bus.mem_rdata, 32'h0);
    end
    drive(32'h0000_0010, 32'h0, 1'b0);
    step();
    checks++;
    if (bus.mem_rdata !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL mid_ram_kept got=%h exp=%h", bus.mem_rdata, 32'hDEAD_BEEF);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_cycle();
    test_ram();
    test_collision();
    test_leds();
    test_tx_stream();
    test_overflow();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
